// File: rtl/trace_pkg.sv
// Shared definitions for the trace array capture block: FSM encodings,
// default readout width and the width helper used for select fields.
package trace_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_POST  = 3'd2,
    ST_DONE  = 3'd3,
    ST_READ  = 3'd4
  } trace_state_t;

  localparam int WORD_WIDTH_DEF = 64;

  // $clog2 that never returns 0, so single-value selects still get a 1-bit field
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // DONE and READ are reported identically on the external state port
  function automatic logic [1:0] state_code(input trace_state_t s);
    logic [1:0] code;
    case (s)
      ST_IDLE:  code = 2'b00;
      ST_ARMED: code = 2'b01;
      ST_POST:  code = 2'b10;
      ST_DONE:  code = 2'b11;
      ST_READ:  code = 2'b11;
      default:  code = 2'b00;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/trace_word_mux.sv
// Combinational word selector: picks word wsel of a wide sample, word 0 being
// the most-significant (lowest-numbered) slice.
module trace_word_mux
  import trace_pkg::*;
#(
  parameter int DATA_IN_WIDTH = 256,
  parameter int WORD_WIDTH    = WORD_WIDTH_DEF,
  parameter int SEL_WIDTH     = 2
) (
  input  logic [0:DATA_IN_WIDTH-1] din,
  input  logic [SEL_WIDTH-1:0]     wsel,
  output logic [0:WORD_WIDTH-1]    dout
);

  localparam int WPE = DATA_IN_WIDTH / WORD_WIDTH;

  // AND-OR select keeps out-of-range wsel values at zero instead of X
  always_comb begin
    dout = {WORD_WIDTH{1'b0}};
    for (int k = 0; k < WPE; k++) begin
      dout = dout | ({WORD_WIDTH{wsel == SEL_WIDTH'(k)}} & din[k*WORD_WIDTH +: WORD_WIDTH]);
    end
  end

endmodule

// File: rtl/trace_array_capture.sv
// Circular trace capture with arm/trigger/post-count control, frozen after
// capture and dumped oldest-first as words over a valid/ready port.
module trace_array_capture
  import trace_pkg::*;
#(
  parameter  int DATA_IN_WIDTH = 256,
  parameter  int WORD_WIDTH    = WORD_WIDTH_DEF,
  parameter  int DEPTH         = 16,
  localparam int WPE           = DATA_IN_WIDTH / WORD_WIDTH,
  localparam int ADDR_WIDTH    = $clog2(DEPTH),
  localparam int SEL_WIDTH     = clog2_min1(WPE)
) (
  input  logic                     ha_pclock,
  input  logic                     reset,
  input  logic [0:DATA_IN_WIDTH-1] data,
  input  logic                     data_valid,
  input  logic                     arm,
  input  logic                     trigger,
  input  logic [0:ADDR_WIDTH]      post_count,
  input  logic                     rd_start,
  output logic [0:WORD_WIDTH-1]    data_out,
  output logic                     data_out_valid,
  input  logic                     data_out_ready,
  output logic                     data_out_last,
  output logic [0:1]               state,
  output logic [0:ADDR_WIDTH]      entries
);

  localparam int                   CNT_WIDTH = ADDR_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] DEPTH_C   = CNT_WIDTH'(DEPTH);
  localparam logic [SEL_WIDTH-1:0] WSEL_LAST = SEL_WIDTH'(WPE - 1);

  trace_state_t             st_r;
  logic [ADDR_WIDTH-1:0]    wptr_r;
  logic [ADDR_WIDTH-1:0]    rptr_r;
  logic [CNT_WIDTH-1:0]     entries_r;
  logic [CNT_WIDTH-1:0]     rem_r;
  logic [CNT_WIDTH-1:0]     rd_ent_r;
  logic [SEL_WIDTH-1:0]     wsel_r;
  logic [0:WORD_WIDTH-1]    data_out_r;
  logic                     valid_r;
  logic                     last_r;
  logic [0:DATA_IN_WIDTH-1] buf_r [DEPTH];

  logic [CNT_WIDTH-1:0]     post_cnt_s;
  logic [CNT_WIDTH-1:0]     post_clamp_s;
  logic [CNT_WIDTH-1:0]     entries_inc_s;
  logic [CNT_WIDTH-1:0]     nxt_ent_s;
  logic [ADDR_WIDTH-1:0]    start_ptr_s;
  logic [ADDR_WIDTH-1:0]    nxt_rptr_s;
  logic [ADDR_WIDTH-1:0]    mux_ptr_s;
  logic [SEL_WIDTH-1:0]     nxt_wsel_s;
  logic [SEL_WIDTH-1:0]     mux_sel_s;
  logic [0:WORD_WIDTH-1]    mux_word_s;
  logic                     wr_en_s;
  logic                     nxt_last_s;
  logic                     start_last_s;

  assign post_cnt_s = post_count;

  // Write qualification, clamps and the position of the word to present next
  always_comb begin
    post_clamp_s  = (post_cnt_s > DEPTH_C) ? DEPTH_C : post_cnt_s;
    entries_inc_s = (entries_r == DEPTH_C) ? DEPTH_C : entries_r + CNT_WIDTH'(1);
    wr_en_s       = data_valid && !arm && ((st_r == ST_ARMED) || (st_r == ST_POST));
    start_ptr_s   = (entries_r == DEPTH_C) ? wptr_r : {ADDR_WIDTH{1'b0}};
    start_last_s  = (entries_r == CNT_WIDTH'(1)) && (WPE == 1);
    if (wsel_r == WSEL_LAST) begin
      nxt_wsel_s = {SEL_WIDTH{1'b0}};
      nxt_rptr_s = rptr_r + ADDR_WIDTH'(1);
      nxt_ent_s  = rd_ent_r + CNT_WIDTH'(1);
    end else begin
      nxt_wsel_s = wsel_r + SEL_WIDTH'(1);
      nxt_rptr_s = rptr_r;
      nxt_ent_s  = rd_ent_r;
    end
    nxt_last_s = (nxt_ent_s == entries_r - CNT_WIDTH'(1)) && (nxt_wsel_s == WSEL_LAST);
    // In DONE the mux looks at the first word so it can be registered on rd_start
    if (st_r == ST_READ) begin
      mux_ptr_s = nxt_rptr_s;
      mux_sel_s = nxt_wsel_s;
    end else begin
      mux_ptr_s = start_ptr_s;
      mux_sel_s = {SEL_WIDTH{1'b0}};
    end
  end

  trace_word_mux #(
    .DATA_IN_WIDTH (DATA_IN_WIDTH),
    .WORD_WIDTH    (WORD_WIDTH),
    .SEL_WIDTH     (SEL_WIDTH)
  ) u_word_mux (
    .din  (buf_r[mux_ptr_s]),
    .wsel (mux_sel_s),
    .dout (mux_word_s)
  );

  // Sample storage; contents are don't-care after reset so no reset term
  always_ff @(posedge ha_pclock) begin
    if (wr_en_s) begin
      buf_r[wptr_r] <= data;
    end
  end

  // Capture/readout FSM with registered readout port
  always_ff @(posedge ha_pclock or posedge reset) begin
    if (reset) begin
      st_r       <= ST_IDLE;
      wptr_r     <= {ADDR_WIDTH{1'b0}};
      rptr_r     <= {ADDR_WIDTH{1'b0}};
      entries_r  <= {CNT_WIDTH{1'b0}};
      rem_r      <= {CNT_WIDTH{1'b0}};
      rd_ent_r   <= {CNT_WIDTH{1'b0}};
      wsel_r     <= {SEL_WIDTH{1'b0}};
      data_out_r <= {WORD_WIDTH{1'b0}};
      valid_r    <= 1'b0;
      last_r     <= 1'b0;
    end else if (arm && (st_r != ST_READ)) begin
      st_r      <= ST_ARMED;
      wptr_r    <= {ADDR_WIDTH{1'b0}};
      entries_r <= {CNT_WIDTH{1'b0}};
      rem_r     <= {CNT_WIDTH{1'b0}};
      valid_r   <= 1'b0;
      last_r    <= 1'b0;
    end else begin
      case (st_r)
        ST_IDLE: begin
        end
        ST_ARMED: begin
          if (wr_en_s) begin
            wptr_r    <= wptr_r + ADDR_WIDTH'(1);
            entries_r <= entries_inc_s;
          end
          if (trigger) begin
            rem_r <= post_clamp_s;
            st_r  <= (post_clamp_s == {CNT_WIDTH{1'b0}}) ? ST_DONE : ST_POST;
          end
        end
        ST_POST: begin
          if (wr_en_s) begin
            wptr_r    <= wptr_r + ADDR_WIDTH'(1);
            entries_r <= entries_inc_s;
            rem_r     <= rem_r - CNT_WIDTH'(1);
            if (rem_r == CNT_WIDTH'(1)) begin
              st_r <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (rd_start && (entries_r != {CNT_WIDTH{1'b0}})) begin
            st_r       <= ST_READ;
            data_out_r <= mux_word_s;
            valid_r    <= 1'b1;
            last_r     <= start_last_s;
            rptr_r     <= start_ptr_s;
            wsel_r     <= {SEL_WIDTH{1'b0}};
            rd_ent_r   <= {CNT_WIDTH{1'b0}};
          end
        end
        ST_READ: begin
          if (valid_r && data_out_ready) begin
            if (last_r) begin
              valid_r <= 1'b0;
              last_r  <= 1'b0;
              st_r    <= ST_DONE;
            end else begin
              data_out_r <= mux_word_s;
              last_r     <= nxt_last_s;
              rptr_r     <= nxt_rptr_s;
              wsel_r     <= nxt_wsel_s;
              rd_ent_r   <= nxt_ent_s;
            end
          end
        end
        default: begin
          st_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign data_out       = data_out_r;
  assign data_out_valid = valid_r;
  assign data_out_last  = last_r;
  assign state          = state_code(st_r);
  assign entries        = entries_r;

endmodule

// File: tb/tb_trace_array_capture.sv
// Directed, table-driven bench for trace_array_capture at default parameters.
module tb_trace_array_capture;

  localparam int DW    = 256;
  localparam int WW    = 64;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          ha_pclock = 1'b0;
  logic          reset;
  logic [0:DW-1] data;
  logic          data_valid;
  logic          arm;
  logic          trigger;
  logic [0:AW]   post_count;
  logic          rd_start;
  logic [0:WW-1] data_out;
  logic          data_out_valid;
  logic          data_out_ready;
  logic          data_out_last;
  logic [0:1]    state;
  logic [0:AW]   entries;

  int checks = 0;
  int errors = 0;

  trace_array_capture #(.DATA_IN_WIDTH(DW), .WORD_WIDTH(WW), .DEPTH(DEPTH)) dut (
    .ha_pclock      (ha_pclock),
    .reset          (reset),
    .data           (data),
    .data_valid     (data_valid),
    .arm            (arm),
    .trigger        (trigger),
    .post_count     (post_count),
    .rd_start       (rd_start),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .data_out_last  (data_out_last),
    .state          (state),
    .entries        (entries)
  );

  always #5 ha_pclock = ~ha_pclock;

  typedef struct {
    bit         rst;
    bit         a;
    bit         t;
    bit         d;
    int         pc;
    bit         rd;
    int         sid;
    logic [1:0] st;
    int         ent;
    int         dn;
    int         dbase;
    int         dmode;
    bit         darm;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] wexp(input int sid, input int k);
    return 64'h5A00_0000_0000_0000 + 64'(sid) * 64'd256 + 64'(k);
  endfunction

  function automatic logic [0:DW-1] mk(input int sid);
    logic [0:DW-1] s;
    for (int k = 0; k < DW / WW; k++) s[k*WW +: WW] = wexp(sid, k);
    return s;
  endfunction

  function automatic vec_t v_cyc(input bit a, input bit t, input bit d, input int pc,
                                 input bit rd, input int sid, input logic [1:0] st, input int ent);
    vec_t v;
    v.rst = 1'b0; v.a = a; v.t = t; v.d = d; v.pc = pc; v.rd = rd; v.sid = sid;
    v.st = st; v.ent = ent; v.dn = -1; v.dbase = 0; v.dmode = 0; v.darm = 1'b0;
    return v;
  endfunction

  function automatic vec_t v_dump(input int base, input int n, input int mode,
                                  input bit darm, input int ent);
    vec_t v;
    v = v_cyc(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 2'b11, ent);
    v.dn = n; v.dbase = base; v.dmode = mode; v.darm = darm;
    return v;
  endfunction

  function automatic vec_t v_rst();
    vec_t v;
    v = v_cyc(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 2'b00, 0);
    v.rst = 1'b1;
    return v;
  endfunction

  task tick();
    @(posedge ha_pclock);
    #1;
  endtask

  task clear_in();
    arm = 1'b0; trigger = 1'b0; data_valid = 1'b0; rd_start = 1'b0;
    post_count = 5'd0; data = {DW{1'b0}};
  endtask

  task automatic apply_cyc(input vec_t v, input int r);
    arm = v.a; trigger = v.t; data_valid = v.d; rd_start = v.rd;
    post_count = 5'(v.pc);
    data = v.d ? mk(v.sid) : {DW{1'b0}};
    tick();
    clear_in();
    chk($sformatf("r%0d_state", r), 64'(state), 64'(v.st));
    chk($sformatf("r%0d_entries", r), 64'(entries), 64'(v.ent));
    chk($sformatf("r%0d_valid", r), 64'(data_out_valid), 64'd0);
  endtask

  task automatic apply_rst(input vec_t v, input int r);
    #2;
    reset = 1'b1;
    #1;
    chk($sformatf("r%0d_async_state", r), 64'(state), 64'(v.st));
    chk($sformatf("r%0d_async_entries", r), 64'(entries), 64'(v.ent));
    chk($sformatf("r%0d_async_valid", r), 64'(data_out_valid), 64'd0);
    chk($sformatf("r%0d_async_last", r), 64'(data_out_last), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    chk($sformatf("r%0d_post_rst_state", r), 64'(state), 64'd0);
  endtask

  task automatic do_dump(input vec_t v, input int r);
    int          idx;
    int          cnt;
    int          total;
    bit          stalled;
    bit          rdy;
    logic [63:0] prev;
    idx = 0; cnt = 0; total = v.dn * 4; stalled = 1'b0; prev = 64'd0;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    if (v.dn == 0) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("r%0d_empty_novalid%0d", r, i), 64'(data_out_valid), 64'd0);
        tick();
      end
    end else begin
      chk($sformatf("r%0d_latency_valid", r), 64'(data_out_valid), 64'd1);
      while (idx < total && cnt < 2000) begin
        rdy = (v.dmode == 0) ? 1'b1 : ((cnt % 6 == 0) || (cnt % 6 == 3) || (cnt % 6 == 5));
        data_out_ready = rdy;
        arm = v.darm && (cnt == 5);
        if (stalled) chk($sformatf("r%0d_hold_w%0d", r, idx), 64'(data_out), prev);
        if (rdy) begin
          chk($sformatf("r%0d_valid_w%0d", r, idx), 64'(data_out_valid), 64'd1);
          chk($sformatf("r%0d_word%0d", r, idx), 64'(data_out), wexp(v.dbase + idx / 4, idx % 4));
          chk($sformatf("r%0d_last_w%0d", r, idx), 64'(data_out_last), 64'(idx == total - 1));
          idx++;
        end
        stalled = !rdy;
        prev = 64'(data_out);
        tick();
        cnt++;
      end
      data_out_ready = 1'b0;
      arm = 1'b0;
      chk($sformatf("r%0d_word_count", r), 64'(idx), 64'(total));
      chk($sformatf("r%0d_end_valid", r), 64'(data_out_valid), 64'd0);
      chk($sformatf("r%0d_end_last", r), 64'(data_out_last), 64'd0);
    end
    chk($sformatf("r%0d_dump_state", r), 64'(state), 64'd3);
    chk($sformatf("r%0d_dump_entries", r), 64'(entries), 64'(v.ent));
  endtask

  initial begin
    clear_in();
    data_out_ready = 1'b0;
    reset = 1'b1;
    #12;
    chk("reset_state", 64'(state), 64'd0);
    chk("reset_entries", 64'(entries), 64'd0);
    chk("reset_valid", 64'(data_out_valid), 64'd0);
    chk("reset_last", 64'(data_out_last), 64'd0);
    chk("reset_data_out", 64'(data_out), 64'd0);
    @(posedge ha_pclock);
    #1;
    reset = 1'b0;

    // IDLE ignores rd_start and data_valid; straight capture 5 pre + 3 post
    tv.push_back(v_cyc(0, 0, 0, 0, 1, 0, 2'b00, 0));
    tv.push_back(v_cyc(0, 0, 1, 0, 0, 50, 2'b00, 0));
    tv.push_back(v_cyc(1, 0, 0, 0, 0, 0, 2'b01, 0));
    for (int i = 0; i < 3; i++) tv.push_back(v_cyc(0, 0, 1, 0, 0, i, 2'b01, i + 1));
    tv.push_back(v_cyc(0, 0, 0, 0, 1, 0, 2'b01, 3));
    for (int i = 3; i < 5; i++) tv.push_back(v_cyc(0, 0, 1, 0, 0, i, 2'b01, i + 1));
    tv.push_back(v_cyc(0, 1, 0, 3, 0, 0, 2'b10, 5));
    tv.push_back(v_cyc(0, 0, 1, 0, 0, 5, 2'b10, 6));
    tv.push_back(v_cyc(0, 1, 1, 0, 0, 6, 2'b10, 7));
    tv.push_back(v_cyc(0, 0, 1, 0, 0, 7, 2'b11, 8));
    tv.push_back(v_cyc(0, 0, 1, 0, 0, 99, 2'b11, 8));
    tv.push_back(v_dump(0, 8, 0, 1'b0, 8));
    tv.push_back(v_dump(0, 8, 1, 1'b1, 8));
    // Wrap: 20 samples into 16 entries, immediate DONE
    tv.push_back(v_cyc(1, 0, 0, 0, 0, 0, 2'b01, 0));
    for (int i = 0; i < 20; i++)
      tv.push_back(v_cyc(0, 0, 1, 0, 0, i, 2'b01, (i + 1 > DEPTH) ? DEPTH : i + 1));
    tv.push_back(v_cyc(0, 1, 0, 0, 0, 0, 2'b11, 16));
    tv.push_back(v_dump(4, 16, 0, 1'b0, 16));
    // post_count 31 clamps to 16; trigger-cycle sample counts as pre-trigger
    tv.push_back(v_cyc(1, 0, 0, 0, 0, 0, 2'b01, 0));
    tv.push_back(v_cyc(0, 0, 1, 0, 0, 0, 2'b01, 1));
    tv.push_back(v_cyc(0, 0, 1, 0, 0, 1, 2'b01, 2));
    tv.push_back(v_cyc(0, 1, 1, 31, 0, 2, 2'b10, 3));
    for (int i = 3; i < 19; i++)
      tv.push_back(v_cyc(0, 0, 1, 0, 0, i, (i == 18) ? 2'b11 : 2'b10,
                         (i + 1 > DEPTH) ? DEPTH : i + 1));
    tv.push_back(v_dump(3, 16, 1, 1'b0, 16));
    // Empty DONE ignores rd_start
    tv.push_back(v_cyc(1, 0, 0, 0, 0, 0, 2'b01, 0));
    tv.push_back(v_cyc(0, 1, 0, 0, 0, 0, 2'b11, 0));
    tv.push_back(v_dump(0, 0, 0, 1'b0, 0));
    // Arm during POST restarts capture
    tv.push_back(v_cyc(1, 0, 0, 0, 0, 0, 2'b01, 0));
    for (int i = 0; i < 3; i++) tv.push_back(v_cyc(0, 0, 1, 0, 0, i, 2'b01, i + 1));
    tv.push_back(v_cyc(0, 1, 0, 5, 0, 0, 2'b10, 3));
    tv.push_back(v_cyc(1, 0, 0, 0, 0, 0, 2'b01, 0));
    // Async reset in POST after 3 samples, then normal operation resumes
    tv.push_back(v_cyc(0, 1, 0, 4, 0, 0, 2'b10, 0));
    for (int i = 0; i < 3; i++) tv.push_back(v_cyc(0, 0, 1, 0, 0, i, 2'b10, i + 1));
    tv.push_back(v_rst());
    tv.push_back(v_cyc(0, 0, 1, 0, 0, 7, 2'b00, 0));
    tv.push_back(v_cyc(1, 0, 0, 0, 0, 0, 2'b01, 0));
    tv.push_back(v_cyc(0, 0, 1, 0, 0, 0, 2'b01, 1));
    tv.push_back(v_cyc(0, 0, 1, 0, 0, 1, 2'b01, 2));
    tv.push_back(v_cyc(0, 1, 0, 0, 0, 0, 2'b11, 2));
    tv.push_back(v_dump(0, 2, 1, 1'b0, 2));

    for (int r = 0; r < tv.size(); r++) begin
      if (tv[r].rst) apply_rst(tv[r], r);
      else if (tv[r].dn >= 0) do_dump(tv[r], r);
      else apply_cyc(tv[r], r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
